// File: rtl/bus_keeper_mux_if.sv
// Bus-side bundle for bus_keeper_mux: source data/enables in, resolved bus and contention status out.
// The master modport belongs to the source side and the slave modport to the mux itself.
interface bus_keeper_mux_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 26,
  parameter int CNT_W = 8
);
  localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_out;
  logic                  err_clr;
  logic [WIDTH-1:0]      BusMuxOut;
  logic                  bus_driven;
  logic [IDX_W-1:0]      winner_idx;
  logic                  contention_flag;
  logic [CNT_W-1:0]      contention_cnt;
  logic [NSRC-1:0]       contention_mask;

  modport master (
    output src_data, src_out, err_clr,
    input  BusMuxOut, bus_driven, winner_idx,
    input  contention_flag, contention_cnt, contention_mask
  );

  modport slave (
    input  src_data, src_out, err_clr,
    output BusMuxOut, bus_driven, winner_idx,
    output contention_flag, contention_cnt, contention_mask
  );
endinterface

// File: rtl/bus_keeper_mux.sv
// Priority bus mux with keeper and sticky contention capture; no backpressure, sources are never stalled.
// Latency 0 cycles (REG_OUT=0) or 1 cycle (REG_OUT=1); contention status is always registered.
module bus_keeper_mux #(
  parameter int WIDTH   = 32,
  parameter int NSRC    = 26,
  parameter int REG_OUT = 0,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             clear,
  bus_keeper_mux_if.slave  bus
);
  localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]  sel_dat;
  logic [IDX_W-1:0]  sel_idx;
  logic              any_vld;
  logic              multi;
  logic [WIDTH-1:0]  keep;
  logic [IDX_W-1:0]  last_idx;
  logic [WIDTH-1:0]  bus_dat;
  logic [IDX_W-1:0]  bus_idx;
  logic              flag;
  logic [CNT_W-1:0]  cnt;
  logic [NSRC-1:0]   mask;

  // Ascending scan so the highest enabled index is the last to assign.
  always_comb begin
    sel_dat = '0;
    sel_idx = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.src_out[i]) begin
        sel_dat = bus.src_data[i*WIDTH +: WIDTH];
        sel_idx = IDX_W'(i);
      end
    end
  end

  assign any_vld = |bus.src_out;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi   = |(bus.src_out & (bus.src_out - NSRC'(1)));

  assign bus_dat = any_vld ? sel_dat : keep;
  assign bus_idx = any_vld ? sel_idx : last_idx;

  always_ff @(posedge clock) begin
    if (!clear) begin
      keep     <= '0;
      last_idx <= '0;
    end else if (any_vld) begin
      keep     <= sel_dat;
      last_idx <= sel_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      flag <= 1'b0;
      cnt  <= '0;
      mask <= '0;
    end else if (bus.err_clr) begin
      flag <= 1'b0;
      cnt  <= '0;
      mask <= '0;
    end else if (multi) begin
      flag <= 1'b1;
      if (!flag) begin
        mask <= bus.src_out;
      end
      if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.contention_flag = flag;
  assign bus.contention_cnt  = cnt;
  assign bus.contention_mask = mask;

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [WIDTH-1:0] out_dat;
      logic             out_vld;
      logic [IDX_W-1:0] out_idx;

      always_ff @(posedge clock) begin
        if (!clear) begin
          out_dat <= '0;
          out_vld <= 1'b0;
          out_idx <= '0;
        end else begin
          out_dat <= bus_dat;
          out_vld <= any_vld;
          out_idx <= bus_idx;
        end
      end

      assign bus.BusMuxOut  = out_dat;
      assign bus.bus_driven = out_vld;
      assign bus.winner_idx = out_idx;
    end else begin : g_comb_out
      assign bus.BusMuxOut  = bus_dat;
      assign bus.bus_driven = any_vld;
      assign bus.winner_idx = bus_idx;
    end
  endgenerate
endmodule
